divisor_multimodo: RTL

DIVISOR_MULTIMODO -- requirements
Module: divisor_multimodo

---
 rtl/divisor_multimodo.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/divisor_multimodo.sv
// divisor_multimodo: iterative restoring divider, unsigned or two's-complement,
// retiring BITS_CICLO quotient bits per clock on sign-stripped magnitudes.
module divisor_multimodo #(
  parameter int tamanyo    = 32,
  parameter int BITS_CICLO = 1
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic               Signo,
  input  logic [tamanyo-1:0] Num,
  input  logic [tamanyo-1:0] Den,
  output logic [tamanyo-1:0] Coc,
  output logic [tamanyo-1:0] Res,
  output logic               Done,
  output logic               Busy,
  output logic               DivCero
);

  localparam int W  = tamanyo;
  localparam int N  = tamanyo / BITS_CICLO;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INI = CW'(N - 1);
  localparam logic [CW-1:0] CNT_CERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_UNO = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ZERO_W = {W{1'b0}};
  localparam logic [W-1:0]  ONE_W = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ONES_W = {W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  function automatic logic [W-1:0] neg2(input logic [W-1:0] v);
    return ~v + ONE_W;
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   accu_q, accu_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   den_q, den_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_coc_q, neg_coc_d;
  logic           neg_res_q, neg_res_d;
  logic           cero_q, cero_d;
  logic [W-1:0]   coc_q, coc_d;
  logic [W-1:0]   res_q, res_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           divcero_q, divcero_d;

  // Next-state and datapath: operand capture, restoring steps, result sign fix-up.
  always_comb begin
    logic [W:0]   sh_v;
    logic [W-1:0] acc_v;
    logic [W-1:0] quo_v;
    state_d   = state_q;
    accu_d    = accu_q;
    quo_d     = quo_q;
    den_d     = den_q;
    cnt_d     = cnt_q;
    neg_coc_d = neg_coc_q;
    neg_res_d = neg_res_q;
    cero_d    = cero_q;
    coc_d     = coc_q;
    res_d     = res_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    divcero_d = divcero_q;
    sh_v      = {1'b0, ZERO_W};
    acc_v     = accu_q;
    quo_v     = quo_q;
    for (int i = 0; i < BITS_CICLO; i++) begin
      sh_v  = {acc_v, quo_v[W-1]};
      quo_v = {quo_v[W-2:0], 1'b0};
      if (sh_v >= {1'b0, den_q}) begin
        acc_v    = sh_v[W-1:0] - den_q;
        quo_v[0] = 1'b1;
      end else begin
        acc_v    = sh_v[W-1:0];
      end
    end
    case (state_q)
      IDLE: begin
        if (Start) begin
          neg_res_d = Signo & Num[W-1];
          neg_coc_d = (Signo & Num[W-1]) ^ (Signo & Den[W-1]);
          accu_d    = ZERO_W;
          cnt_d     = CNT_INI;
          busy_d    = 1'b1;
          den_d     = (Signo & Den[W-1]) ? neg2(Den) : Den;
          // A zero divisor keeps Num untouched in the quotient register for FIN.
          if (Den == ZERO_W) begin
            cero_d  = 1'b1;
            quo_d   = Num;
            state_d = FIN;
          end else begin
            cero_d  = 1'b0;
            quo_d   = (Signo & Num[W-1]) ? neg2(Num) : Num;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        accu_d = acc_v;
        quo_d  = quo_v;
        cnt_d  = cnt_q - CNT_UNO;
        if (cnt_q == CNT_CERO) begin
          state_d = FIN;
        end else begin
          state_d = CALC;
        end
      end
      FIN: begin
        if (cero_q) begin
          coc_d = ONES_W;
          res_d = quo_q;
        end else begin
          coc_d = neg_coc_q ? neg2(quo_q) : quo_q;
          res_d = neg_res_q ? neg2(accu_q) : accu_q;
        end
        divcero_d = cero_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q   <= IDLE;
      accu_q    <= ZERO_W;
      quo_q     <= ZERO_W;
      den_q     <= ZERO_W;
      cnt_q     <= CNT_CERO;
      neg_coc_q <= 1'b0;
      neg_res_q <= 1'b0;
      cero_q    <= 1'b0;
      coc_q     <= ZERO_W;
      res_q     <= ZERO_W;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      divcero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      accu_q    <= accu_d;
      quo_q     <= quo_d;
      den_q     <= den_d;
      cnt_q     <= cnt_d;
      neg_coc_q <= neg_coc_d;
      neg_res_q <= neg_res_d;
      cero_q    <= cero_d;
      coc_q     <= coc_d;
      res_q     <= res_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      divcero_q <= divcero_d;
    end
  end

  assign Coc     = coc_q;
  assign Res     = res_q;
  assign Done    = done_q;
  assign Busy    = busy_q;
  assign DivCero = divcero_q;

endmodule
